// File: rtl/rob_commit_unit.sv
// Reorder buffer: allocates one entry per renamed instruction, captures CDB results,
// and retires at most one instruction per cycle in program order onto registered commit outputs.
module rob_commit_unit #(
    parameter int ROB_DEPTH = 16,
    parameter int TAG_W     = $clog2(ROB_DEPTH),
    parameter int PHY_REG_W = 6,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,

    input  logic                 alloc_valid,
    input  logic                 alloc_has_dst,
    input  logic [4:0]           alloc_arch_rd,
    input  logic [PHY_REG_W-1:0] alloc_phy_rd,
    output logic [TAG_W-1:0]     alloc_tag,
    output logic                 rob_full,

    input  logic                 cdb_valid,
    input  logic [TAG_W-1:0]     cdb_tag,
    input  logic [DATA_W-1:0]    cdb_data,

    output logic                 commit_valid,
    output logic [TAG_W-1:0]     commit_tag,
    output logic                 commit_with_write,
    output logic [4:0]           commit_arch_reg,
    output logic [PHY_REG_W-1:0] commit_phy_reg_addr,
    output logic [DATA_W-1:0]    commit_data
);

    localparam int PTR_W = TAG_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(ROB_DEPTH);

    // Pointers carry a wrap bit so full and empty stay distinguishable.
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] count;

    logic [TAG_W-1:0] head_idx;
    logic [TAG_W-1:0] tail_idx;

    logic [ROB_DEPTH-1:0] ent_valid;
    logic [ROB_DEPTH-1:0] ent_done;
    logic [ROB_DEPTH-1:0] ent_has_dst;
    logic [4:0]           ent_arch_rd [ROB_DEPTH];
    logic [PHY_REG_W-1:0] ent_phy_rd  [ROB_DEPTH];
    logic [DATA_W-1:0]    ent_data    [ROB_DEPTH];

    logic alloc_fire;
    logic cdb_hit;
    logic retire_fire;

    assign head_idx  = head[TAG_W-1:0];
    assign tail_idx  = tail[TAG_W-1:0];

    assign rob_full  = (count == DEPTH_CNT);
    assign alloc_tag = tail_idx;

    assign alloc_fire  = alloc_valid && !rob_full;
    assign cdb_hit     = cdb_valid && ent_valid[cdb_tag];
    assign retire_fire = ent_valid[head_idx] && ent_done[head_idx];

    for (genvar i = 0; i < ROB_DEPTH; i++) begin : g_entry
        logic                 sel_alloc;
        logic                 sel_cdb;
        logic                 sel_retire;
        logic                 valid_q;
        logic                 done_q;
        logic                 has_dst_q;
        logic [4:0]           arch_rd_q;
        logic [PHY_REG_W-1:0] phy_rd_q;
        logic [DATA_W-1:0]    data_q;

        assign sel_alloc  = alloc_fire  && (tail_idx == TAG_W'(i));
        assign sel_cdb    = cdb_hit     && (cdb_tag  == TAG_W'(i));
        assign sel_retire = retire_fire && (head_idx == TAG_W'(i));

        // An allocating entry is never valid, so alloc and CDB never target the same entry.
        always_ff @(posedge clk) begin
            if (reset || flush) begin
                valid_q <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                if (sel_alloc) begin
                    valid_q <= 1'b1;
                    done_q  <= 1'b0;
                end else begin
                    if (sel_retire) begin
                        valid_q <= 1'b0;
                    end
                    if (sel_cdb) begin
                        done_q <= 1'b1;
                    end
                end
            end
        end

        // Payload needs no reset; it is only observed behind valid/done.
        always_ff @(posedge clk) begin
            if (sel_alloc) begin
                has_dst_q <= alloc_has_dst;
                arch_rd_q <= alloc_arch_rd;
                phy_rd_q  <= alloc_phy_rd;
                data_q    <= '0;
            end else if (sel_cdb) begin
                data_q <= cdb_data;
            end
        end

        assign ent_valid[i]   = valid_q;
        assign ent_done[i]    = done_q;
        assign ent_has_dst[i] = has_dst_q;
        assign ent_arch_rd[i] = arch_rd_q;
        assign ent_phy_rd[i]  = phy_rd_q;
        assign ent_data[i]    = data_q;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc_fire) begin
                tail <= tail + PTR_W'(1);
            end
            if (retire_fire) begin
                head <= head + PTR_W'(1);
            end
            case ({alloc_fire, retire_fire})
                2'b10:   count <= count + PTR_W'(1);
                2'b01:   count <= count - PTR_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Flush only drops commit_valid; the payload outputs keep their last values.
    always_ff @(posedge clk) begin
        if (reset) begin
            commit_valid        <= 1'b0;
            commit_tag          <= '0;
            commit_with_write   <= 1'b0;
            commit_arch_reg     <= '0;
            commit_phy_reg_addr <= '0;
            commit_data         <= '0;
        end else if (flush) begin
            commit_valid <= 1'b0;
        end else if (retire_fire) begin
            commit_valid        <= 1'b1;
            commit_tag          <= head_idx;
            commit_with_write   <= ent_has_dst[head_idx] && (ent_arch_rd[head_idx] != 5'd0);
            commit_arch_reg     <= ent_arch_rd[head_idx];
            commit_phy_reg_addr <= ent_phy_rd[head_idx];
            commit_data         <= ent_data[head_idx];
        end else begin
            commit_valid <= 1'b0;
        end
    end

endmodule
